// File: rtl/pd_tx_symbol_gen_pkg.sv
// Shared USB-PD TX definitions: K-code symbol indices, tx_kind encodings,
// CRC32 constants, FSM state type and the ordered-set lookup.
package pd_pkg;

  localparam logic [3:0] K_SYNC1 = 4'd0;
  localparam logic [3:0] K_SYNC2 = 4'd1;
  localparam logic [3:0] K_RST1  = 4'd2;
  localparam logic [3:0] K_RST2  = 4'd3;
  localparam logic [3:0] K_EOP   = 4'd4;
  localparam logic [3:0] K_SYNC3 = 4'd5;

  localparam logic [1:0] KIND_SOP        = 2'd0;
  localparam logic [1:0] KIND_SOP_P      = 2'd1;
  localparam logic [1:0] KIND_SOP_PP     = 2'd2;
  localparam logic [1:0] KIND_HARD_RESET = 2'd3;

  localparam logic [31:0] CRC32_POLY       = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_POLY_REFL  = {<<{CRC32_POLY}};
  localparam logic [31:0] CRC_INIT_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ORDSET,
    ST_LOAD,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CRC,
    ST_EOP
  } state_t;

  // K-code index of symbol idx (0..3) within the ordered set for a frame kind.
  function automatic logic [3:0] ordset_code(input logic [1:0] kind, input logic [1:0] idx);
    logic [3:0] code;
    code = K_SYNC1;
    case (kind)
      KIND_SOP:    code = (idx == 2'd3) ? K_SYNC2 : K_SYNC1;
      KIND_SOP_P:  code = idx[1] ? K_SYNC3 : K_SYNC1;
      KIND_SOP_PP: code = idx[0] ? K_SYNC3 : K_SYNC1;
      default:     code = (idx == 2'd3) ? K_RST2 : K_RST1;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pd_tx_symbol_gen_if.sv
// Byte-stream input and symbol-output handshakes of the PD TX symbol generator.
interface pd_tx_symbol_gen_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic [3:0] sym_din;
  logic       sym_ext;
  logic       sym_valid;
  logic       sym_ready;

  modport master (
    input  tx_data, tx_valid, tx_last, sym_ready,
    output tx_ready, sym_din, sym_ext, sym_valid
  );

  modport slave (
    output tx_data, tx_valid, tx_last, sym_ready,
    input  tx_ready, sym_din, sym_ext, sym_valid
  );
endinterface

// File: rtl/pd_crc32_byte.sv
// Combinational reflected CRC32 step over one byte, LSB first (shared with the RX checker).
module pd_crc32_byte
  import pd_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  always_comb begin
    c = crc ^ {24'd0, data};
    for (int unsigned b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_next = c;
  end

endmodule

// File: rtl/pd_tx_symbol_gen.sv
// USB-PD TX symbol generator: ordered set, payload nibbles, CRC32 nibbles, EOP.
// Optional build macro PD_TX_UNDERRUN_ABORT_EN: an empty LOAD cycle aborts the frame with EOP.
module pd_tx_symbol_gen
  import pd_pkg::*;
#(
  parameter logic [31:0] CRC_INIT  = CRC_INIT_DEFAULT,
  parameter int unsigned MAX_BYTES = 262
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_start,
  input  logic [1:0]                tx_kind,
  pd_tx_symbol_gen_if.master        bus,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic                      tx_err
);

  localparam logic [8:0] BCNT_LAST = 9'(MAX_BYTES - 1);

  state_t      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic [1:0]  ocnt_q, ocnt_d;
  logic [2:0]  ncnt_q, ncnt_d;
  logic [8:0]  bcnt_q, bcnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic [31:0] crc_q, crc_d, crc_upd, crc_fin;
  logic [3:0]  sym_din_q, sym_din_d;
  logic        sym_ext_q, sym_ext_d;
  logic        sym_valid_q, sym_valid_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic        hs;
  logic [2:0]  ncnt_inc;

  pd_crc32_byte u_crc (
    .crc      (crc_q),
    .data     (bus.tx_data),
    .crc_next (crc_upd)
  );

  assign crc_fin  = ~crc_q;
  assign ncnt_inc = ncnt_q + 3'd1;
  assign hs       = sym_valid_q & bus.sym_ready;

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    ocnt_d      = ocnt_q;
    ncnt_d      = ncnt_q;
    bcnt_d      = bcnt_q;
    byte_d      = byte_q;
    last_d      = last_q;
    crc_d       = crc_q;
    sym_din_d   = sym_din_q;
    sym_ext_d   = sym_ext_q;
    sym_valid_d = sym_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: if (tx_start) begin
        kind_d      = tx_kind;
        ocnt_d      = '0;
        bcnt_d      = '0;
        crc_d       = CRC_INIT;
        busy_d      = 1'b1;
        sym_valid_d = 1'b1;
        sym_ext_d   = 1'b1;
        sym_din_d   = ordset_code(tx_kind, 2'd0);
        state_d     = ST_ORDSET;
      end
      ST_ORDSET: if (hs) begin
        if (ocnt_q != 2'd3) begin
          ocnt_d    = ocnt_q + 2'd1;
          sym_din_d = ordset_code(kind_q, ocnt_q + 2'd1);
        end else if (kind_q == KIND_HARD_RESET) begin
          sym_valid_d = 1'b0;
          sym_ext_d   = 1'b0;
          sym_din_d   = '0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          sym_valid_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: if (bus.tx_valid) begin
        byte_d      = bus.tx_data;
        last_d      = bus.tx_last;
        crc_d       = crc_upd;
        bcnt_d      = bcnt_q + 9'd1;
        // The MAX_BYTES-th byte without tx_last is promoted to last.
        if (!bus.tx_last && bcnt_q == BCNT_LAST) begin
          last_d = 1'b1;
          err_d  = 1'b1;
        end
        sym_valid_d = 1'b1;
        sym_ext_d   = 1'b0;
        sym_din_d   = bus.tx_data[3:0];
        state_d     = ST_DATA_LO;
      end else begin
`ifdef PD_TX_UNDERRUN_ABORT_EN
        sym_valid_d = 1'b1;
        sym_ext_d   = 1'b1;
        sym_din_d   = K_EOP;
        err_d       = 1'b1;
        state_d     = ST_EOP;
`else
        state_d     = ST_LOAD;
`endif
      end
      ST_DATA_LO: if (hs) begin
        sym_din_d = byte_q[7:4];
        state_d   = ST_DATA_HI;
      end
      ST_DATA_HI: if (hs) begin
        if (last_q) begin
          ncnt_d    = '0;
          sym_din_d = crc_fin[3:0];
          state_d   = ST_CRC;
        end else begin
          sym_valid_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_CRC: if (hs) begin
        if (ncnt_q == 3'd7) begin
          sym_ext_d = 1'b1;
          sym_din_d = K_EOP;
          state_d   = ST_EOP;
        end else begin
          ncnt_d    = ncnt_inc;
          sym_din_d = crc_fin[{ncnt_inc, 2'b00} +: 4];
        end
      end
      ST_EOP: if (hs) begin
        sym_valid_d = 1'b0;
        sym_ext_d   = 1'b0;
        sym_din_d   = '0;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      kind_q      <= '0;
      ocnt_q      <= '0;
      ncnt_q      <= '0;
      bcnt_q      <= '0;
      byte_q      <= '0;
      last_q      <= 1'b0;
      crc_q       <= CRC_INIT;
      sym_din_q   <= '0;
      sym_ext_q   <= 1'b0;
      sym_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      ocnt_q      <= ocnt_d;
      ncnt_q      <= ncnt_d;
      bcnt_q      <= bcnt_d;
      byte_q      <= byte_d;
      last_q      <= last_d;
      crc_q       <= crc_d;
      sym_din_q   <= sym_din_d;
      sym_ext_q   <= sym_ext_d;
      sym_valid_q <= sym_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.tx_ready  = (state_q == ST_LOAD);
  assign bus.sym_din   = sym_din_q;
  assign bus.sym_ext   = sym_ext_q;
  assign bus.sym_valid = sym_valid_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;
  assign tx_err        = err_q;

endmodule

// File: tb/tb_pd_tx_symbol_gen.sv
// Self-checking bench for pd_tx_symbol_gen: directed and randomized frames against a symbol-list model.
module tb_pd_tx_symbol_gen;

  localparam int unsigned MAXB = 262;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [1:0] tx_kind;
  logic       tx_busy, tx_done, tx_err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] bytes[$];
  logic [4:0] exp_q[$];
  int gap_at = -1;
  int gap_len = 0;
  int accepted, err_cnt, err_at, ready_seen, gap_cnt;

  // {ext, code}: ordered sets written as K-code numbers (S1=0, S2=1, R1=2, R2=3, S3=5).
  logic [3:0] os_tab [4][4] = '{'{4'd0, 4'd0, 4'd0, 4'd1},
                                '{4'd0, 4'd0, 4'd5, 4'd5},
                                '{4'd0, 4'd5, 4'd0, 4'd5},
                                '{4'd2, 4'd2, 4'd2, 4'd3}};

  pd_tx_symbol_gen_if bus ();

  pd_tx_symbol_gen #(.CRC_INIT(32'hFFFF_FFFF), .MAX_BYTES(MAXB)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_kind  (tx_kind),
    .bus      (bus),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .tx_err   (tx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sym_valid"}, bus.sym_valid, 1'b0);
    check({tag, "_sym_din"}, bus.sym_din, 4'h0);
    check({tag, "_sym_ext"}, bus.sym_ext, 1'b0);
    check({tag, "_tx_ready"}, bus.tx_ready, 1'b0);
    check({tag, "_tx_busy"}, tx_busy, 1'b0);
    check({tag, "_tx_done"}, tx_done, 1'b0);
    check({tag, "_tx_err"}, tx_err, 1'b0);
  endtask

  // Final (inverted) reflected CRC32 over the first n payload bytes.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, bytes[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_exp(input logic [1:0] kind, input int nbytes, input bit with_crc);
    logic [31:0] c;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, os_tab[kind][i]});
    if (kind != 2'd3) begin
      for (int b = 0; b < nbytes; b++) begin
        exp_q.push_back({1'b0, bytes[b][3:0]});
        exp_q.push_back({1'b0, bytes[b][7:4]});
      end
      if (with_crc) begin
        c = ref_crc(nbytes);
        for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, c[4*k +: 4]});
      end
      exp_q.push_back(5'h14);
    end
  endtask

  task automatic run_frame(input logic [1:0] kind, input int nfeed, input bit give_last,
                           input int ready_pct);
    int idx = 0;
    int extra = 0;
    bit finished = 1'b0;
    bit prev_stall = 1'b0;
    bit gap;
    logic [4:0] prev_sym = '0;
    logic [4:0] cur;
    accepted = 0; err_cnt = 0; err_at = -1; ready_seen = 0; gap_cnt = 0;
    @(negedge clk);
    tx_start = 1'b1;
    tx_kind  = kind;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      tx_start = 1'b0;
      cur = {bus.sym_ext, bus.sym_din};
      if (cyc == 0) check("start_latency", bus.sym_valid, 1'b1);
      if (prev_stall) check("stall_hold", cur, prev_sym);
      if (tx_err) begin err_cnt++; err_at = accepted; end
      if (tx_done) begin
        check("busy_at_done", tx_busy, 1'b0);
        check("symbols_left", exp_q.size(), 0);
        finished = 1'b1;
      end else begin
        if (bus.tx_ready) begin
          ready_seen++;
          check("load_no_sym", bus.sym_valid, 1'b0);
        end
        gap = (idx == gap_at) && (gap_cnt < gap_len);
        bus.tx_valid = (idx < nfeed) && !gap;
        bus.tx_last  = give_last && (idx == nfeed - 1);
        if (idx < nfeed) bus.tx_data = bytes[idx];
        if (bus.tx_ready) begin
          if (bus.tx_valid) begin idx++; accepted++; end
          else if (gap) gap_cnt++;
        end
        bus.sym_ready = ($urandom_range(99) < ready_pct);
        if (bus.sym_valid && bus.sym_ready) begin
          if (exp_q.size() > 0) check("symbol", cur, exp_q.pop_front());
          else extra++;
        end
        prev_stall = bus.sym_valid && !bus.sym_ready;
        prev_sym   = cur;
        if (cyc == 10) begin tx_start = 1'b1; tx_kind = ~kind; end
      end
    end
    check("frame_done", finished, 1'b1);
    check("extra_symbols", extra, 0);
    bus.sym_ready = 1'b0;
    bus.tx_valid  = 1'b0;
    bus.tx_last   = 1'b0;
  endtask

  initial begin
    logic [1:0] kind;
    int n;
    bit found;
    rst = 1'b1; tx_start = 1'b0; tx_kind = 2'd0;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b0; bus.tx_last = 1'b0; bus.sym_ready = 1'b0;
    #1;
    check_idle("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // SOP with "123456789": CRC 0xCBF43926 sent low nibble first.
    bytes = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp_q = {5'h10, 5'h10, 5'h10, 5'h11,
             5'h01, 5'h03, 5'h02, 5'h03, 5'h03, 5'h03, 5'h04, 5'h03, 5'h05, 5'h03,
             5'h06, 5'h03, 5'h07, 5'h03, 5'h08, 5'h03, 5'h09, 5'h03,
             5'h06, 5'h02, 5'h09, 5'h03, 5'h04, 5'h0F, 5'h0B, 5'h0C, 5'h14};
    run_frame(2'd0, 9, 1'b1, 100);
    check("check_string_err", err_cnt, 0);

    bytes.delete();
    build_exp(2'd3, 0, 1'b0);
    run_frame(2'd3, 0, 1'b0, 60);
    check("hard_reset_ready", ready_seen, 0);
    check("hard_reset_err", err_cnt, 0);

    bytes = {8'hA5};
    build_exp(2'd2, 1, 1'b1);
    run_frame(2'd2, 1, 1'b1, 50);

    for (int f = 0; f < 6; f++) begin
      kind = 2'($urandom_range(2));
      n = $urandom_range(1, 24);
      bytes.delete();
      for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
      build_exp(kind, n, 1'b1);
      run_frame(kind, n, 1'b1, $urandom_range(30, 100));
      check("rand_accepted", accepted, n);
      check("rand_err", err_cnt, 0);
    end

    bytes.delete();
    for (int i = 0; i < int'(MAXB) + 1; i++) bytes.push_back(8'($urandom));
    build_exp(2'd0, MAXB, 1'b1);
    run_frame(2'd0, MAXB + 1, 1'b0, 100);
    check("ovf_accepted", accepted, MAXB);
    check("ovf_err_count", err_cnt, 1);
    check("ovf_err_byte", err_at, MAXB);

    // Asynchronous reset while the high nibble of the first byte is on the bus.
    bus.tx_data = 8'h11; bus.tx_valid = 1'b1; bus.tx_last = 1'b0; bus.sym_ready = 1'b1;
    @(negedge clk);
    tx_start = 1'b1; tx_kind = 2'd0;
    @(negedge clk);
    tx_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (bus.sym_valid && !bus.sym_ext) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_data_lo", found, 1'b1);
    @(negedge clk);
    check("data_hi_sym", {bus.sym_valid, bus.sym_ext, bus.sym_din}, 6'h21);
    #1 rst = 1'b1;
    #1 check_idle("midframe_rst");
    @(negedge clk);
    rst = 1'b0; bus.tx_valid = 1'b0; bus.sym_ready = 1'b0;
    bytes.delete();
    for (int i = 0; i < 5; i++) bytes.push_back(8'($urandom));
    build_exp(2'd1, 5, 1'b1);
    run_frame(2'd1, 5, 1'b1, 80);

    bytes = {8'($urandom), 8'($urandom), 8'($urandom)};
    gap_at = 1; gap_len = 4;
`ifdef PD_TX_UNDERRUN_ABORT_EN
    build_exp(2'd0, 1, 1'b0);
    run_frame(2'd0, 3, 1'b1, 100);
    check("underrun_err", err_cnt, 1);
    check("underrun_gap", gap_cnt, 1);
`else
    build_exp(2'd0, 3, 1'b1);
    run_frame(2'd0, 3, 1'b1, 100);
    check("underrun_err", err_cnt, 0);
    check("underrun_gap", gap_cnt, 4);
`endif
    gap_at = -1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
